// File: rtl/hpu_pkg.sv
// Purpose : shared types and constants for the HPU sprite fetch path.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: fetch FSM state enum, OAM field offsets, pattern geometry,
//           sprite engine count and a pattern-row address helper.
package hpu_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_Y,
      S_CHK_Y,
      S_RD_X,
      S_RD_T,
      S_RD_A,
      S_RD_P0,
      S_RD_P1,
      S_RD_P2,
      S_COMMIT
   } fetch_state_e;

   // Byte offsets of the four fields inside one OAM entry.
   localparam logic [1:0] OFS_Y    = 2'd0;
   localparam logic [1:0] OFS_X    = 2'd1;
   localparam logic [1:0] OFS_TILE = 2'd2;
   localparam logic [1:0] OFS_ATTR = 2'd3;

   // 3bpp pattern: 8 rows of 3 bytes per tile.
   localparam logic [15:0] BYTES_PER_TILE = 16'd24;
   localparam logic [15:0] BYTES_PER_ROW  = 16'd3;

   localparam int NUM_SPRITE_ENGINES = 16;

   // Address of byte k of pattern row 'row' of tile 'tile'; wraps at 16 bits.
   function automatic logic [15:0] pat_addr(input logic [15:0] base,
                                            input logic [7:0]  tile,
                                            input logic [2:0]  row,
                                            input logic [1:0]  k);
      return base + (16'(tile) * BYTES_PER_TILE) + (16'(row) * BYTES_PER_ROW) + 16'(k);
   endfunction

endpackage

// File: rtl/hpu_sprite_fetch_if.sv
// Purpose : memory bus handshake plus sprite slot write port of the fetcher.
// Latency : n/a (wires only); read data returns one cycle after its address.
// Backpr. : bus_gnt low holds the requester in its address cycle.
// Ports   : bus_req/bus_gnt/addr_out/data_in = shared 8-bit read bus;
//           slot_* = one-cycle slot write strobe with fields, slot_enable mask.
interface hpu_sprite_fetch_if;
   import hpu_pkg::*;

   logic        bus_req;
   logic        bus_gnt;
   logic [15:0] addr_out;
   logic [7:0]  data_in;

   logic        slot_we;
   logic [3:0]  slot_idx;
   logic [7:0]  slot_x;
   logic [7:0]  slot_y;
   logic [1:0]  slot_pallet;
   logic [23:0] slot_line_buf;
   logic [NUM_SPRITE_ENGINES-1:0] slot_enable;

   // Fetcher side.
   modport master (
      output bus_req, addr_out,
      output slot_we, slot_idx, slot_x, slot_y, slot_pallet, slot_line_buf, slot_enable,
      input  bus_gnt, data_in
   );

   // Memory / arbiter / sprite engine side.
   modport slave (
      input  bus_req, addr_out,
      input  slot_we, slot_idx, slot_x, slot_y, slot_pallet, slot_line_buf, slot_enable,
      output bus_gnt, data_in
   );

endinterface

// File: rtl/hpu_sprite_fetch.sv
// Purpose : hblank sprite scan of OAM for the next logical line, then pattern
//           row fetch and load of up to 16 sprite engine slots.
// Latency : 2 cycles per read (addr, data); miss 3 cycles, hit 16 cycles.
// Backpr. : bus_gnt low stalls the address cycle; grant loss in data ignored.
// Ports   : clk, reset (sync, active high); true_line/true_column raster;
//           fif = bus + slot interface (master); busy, done pulse, late pulse.
module hpu_sprite_fetch
   import hpu_pkg::*;
#(
   parameter int unsigned  NUM_OAM      = 40,
   parameter logic [15:0]  OAM_BASE     = 16'hFE00,
   parameter logic [15:0]  PAT_BASE     = 16'h8000,
   parameter logic [9:0]   HBLANK_START = 10'd640,
   parameter logic [9:0]   ABORT_COL    = 10'd799,
   parameter logic [9:0]   LAST_LINE    = 10'd524
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          true_line,
   input  logic [9:0]          true_column,
   hpu_sprite_fetch_if.master  fif,
   output logic                busy,
   output logic                done,
   output logic                late
);

   localparam int IDX_W = $clog2(NUM_OAM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OAM - 1);
   localparam logic [4:0]       LAST_SLOT = 5'(NUM_SPRITE_ENGINES - 1);

   // Entry i field f sits at OAM_BASE + 4*i + f, i.e. {i, f}.
   function automatic logic [15:0] oam_addr(input logic [IDX_W-1:0] i,
                                            input logic [1:0]       f);
      return OAM_BASE + 16'({i, f});
   endfunction

   fetch_state_e       state_q, state_d;
   logic               phase_q, phase_d;        // 0 = address cycle, 1 = data cycle
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [4:0]         slot_cnt_q, slot_cnt_d;
   logic [7:0]         next_line_q, next_line_d;
   logic [2:0]         row_q, row_d;
   logic [7:0]         tile_q, tile_d;
   logic [15:0]        addr_q, addr_d;
   logic               bus_req_q, bus_req_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               late_q, late_d;
   logic               slot_we_q, slot_we_d;
   logic [3:0]         slot_idx_q, slot_idx_d;
   logic [7:0]         slot_x_q, slot_x_d;
   logic [7:0]         slot_y_q, slot_y_d;
   logic [1:0]         slot_pal_q, slot_pal_d;
   logic [23:0]        slot_buf_q, slot_buf_d;
   logic [NUM_SPRITE_ENGINES-1:0] slot_en_q, slot_en_d;

   logic               trigger;
   logic               abort;
   logic               finish;
   logic [7:0]         diff;
   logic               y_hit;

   // Jobs start only on odd lines (and the frame's last line) at hblank.
   assign trigger = (state_q == S_IDLE) && (true_column == HBLANK_START) &&
                    (true_line[0] || (true_line == LAST_LINE));
   assign abort   = busy_q && (true_column == ABORT_COL);

   // Modulo-256 distance handles sprites that straddle the top of the screen.
   assign diff  = next_line_q - slot_y_q;
   assign y_hit = (diff[7:3] == 5'd0);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      idx_d       = idx_q;
      slot_cnt_d  = slot_cnt_q;
      next_line_d = next_line_q;
      row_d       = row_q;
      tile_d      = tile_q;
      addr_d      = addr_q;
      bus_req_d   = bus_req_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      late_d      = 1'b0;
      slot_we_d   = 1'b0;
      slot_idx_d  = slot_idx_q;
      slot_x_d    = slot_x_q;
      slot_y_d    = slot_y_q;
      slot_pal_d  = slot_pal_q;
      slot_buf_d  = slot_buf_q;
      slot_en_d   = slot_en_q;
      finish      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               next_line_d = (true_line == LAST_LINE) ? 8'd0
                                                      : 8'((true_line[8:0] + 9'd1) >> 1);
               slot_en_d   = '0;
               idx_d       = '0;
               slot_cnt_d  = '0;
               busy_d      = 1'b1;
               bus_req_d   = 1'b1;
               phase_d     = 1'b0;
               addr_d      = oam_addr('0, OFS_Y);
               state_d     = S_RD_Y;
            end
         end

         S_RD_Y: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               slot_y_d = fif.data_in;
               state_d  = S_CHK_Y;
            end
         end

         S_CHK_Y: begin
            if (y_hit) begin
               row_d   = diff[2:0];
               addr_d  = oam_addr(idx_q, OFS_X);
               state_d = S_RD_X;
            end else if (idx_q == LAST_IDX) begin
               finish = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               addr_d  = oam_addr(idx_q + 1'b1, OFS_Y);
               state_d = S_RD_Y;
            end
         end

         S_RD_X: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               slot_x_d = fif.data_in;
               addr_d   = oam_addr(idx_q, OFS_TILE);
               state_d  = S_RD_T;
            end
         end

         S_RD_T: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               tile_d  = fif.data_in;
               addr_d  = oam_addr(idx_q, OFS_ATTR);
               state_d = S_RD_A;
            end
         end

         S_RD_A: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d    = 1'b0;
               slot_pal_d = fif.data_in[1:0];
               addr_d     = pat_addr(PAT_BASE, tile_q, row_q, 2'd0);
               state_d    = S_RD_P0;
            end
         end

         S_RD_P0: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d          = 1'b0;
               slot_buf_d[7:0]  = fif.data_in;
               addr_d           = pat_addr(PAT_BASE, tile_q, row_q, 2'd1);
               state_d          = S_RD_P1;
            end
         end

         S_RD_P1: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               phase_d          = 1'b0;
               slot_buf_d[15:8] = fif.data_in;
               addr_d           = pat_addr(PAT_BASE, tile_q, row_q, 2'd2);
               state_d          = S_RD_P2;
            end
         end

         S_RD_P2: begin
            if (!phase_q) begin
               if (fif.bus_gnt) phase_d = 1'b1;
            end else begin
               // Strobe and mask are registered, so they appear during COMMIT.
               phase_d                     = 1'b0;
               slot_buf_d[23:16]           = fif.data_in;
               slot_we_d                   = 1'b1;
               slot_idx_d                  = slot_cnt_q[3:0];
               slot_en_d[slot_cnt_q[3:0]]  = 1'b1;
               state_d                     = S_COMMIT;
            end
         end

         S_COMMIT: begin
            slot_cnt_d = slot_cnt_q + 1'b1;
            if ((slot_cnt_q == LAST_SLOT) || (idx_q == LAST_IDX)) begin
               finish = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               addr_d  = oam_addr(idx_q + 1'b1, OFS_Y);
               state_d = S_RD_Y;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (finish) begin
         state_d   = S_IDLE;
         phase_d   = 1'b0;
         busy_d    = 1'b0;
         bus_req_d = 1'b0;
         done_d    = 1'b1;
      end

      // Abort wins over everything still in flight. A commit already on the
      // slot port stays; a sprite whose last byte lands now is dropped.
      if (abort) begin
         state_d   = S_IDLE;
         phase_d   = 1'b0;
         busy_d    = 1'b0;
         bus_req_d = 1'b0;
         done_d    = 1'b0;
         late_d    = 1'b1;
         slot_we_d = 1'b0;
         slot_en_d = slot_en_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         idx_q       <= '0;
         slot_cnt_q  <= '0;
         next_line_q <= '0;
         row_q       <= '0;
         tile_q      <= '0;
         addr_q      <= '0;
         bus_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         late_q      <= 1'b0;
         slot_we_q   <= 1'b0;
         slot_idx_q  <= '0;
         slot_x_q    <= '0;
         slot_y_q    <= '0;
         slot_pal_q  <= '0;
         slot_buf_q  <= '0;
         slot_en_q   <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         slot_cnt_q  <= slot_cnt_d;
         next_line_q <= next_line_d;
         row_q       <= row_d;
         tile_q      <= tile_d;
         addr_q      <= addr_d;
         bus_req_q   <= bus_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         late_q      <= late_d;
         slot_we_q   <= slot_we_d;
         slot_idx_q  <= slot_idx_d;
         slot_x_q    <= slot_x_d;
         slot_y_q    <= slot_y_d;
         slot_pal_q  <= slot_pal_d;
         slot_buf_q  <= slot_buf_d;
         slot_en_q   <= slot_en_d;
      end
   end

   assign fif.bus_req       = bus_req_q;
   assign fif.addr_out      = addr_q;
   assign fif.slot_we       = slot_we_q;
   assign fif.slot_idx      = slot_idx_q;
   assign fif.slot_x        = slot_x_q;
   assign fif.slot_y        = slot_y_q;
   assign fif.slot_pallet   = slot_pal_q;
   assign fif.slot_line_buf = slot_buf_q;
   assign fif.slot_enable   = slot_en_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign late              = late_q;

endmodule

// File: tb/tb_hpu_sprite_fetch.sv
// Purpose : self-checking bench for hpu_sprite_fetch with a byte memory model.
// Latency : memory returns data one cycle after the presented address.
// Backpr. : bus_gnt driven by the bench, normally high, dropped for stalls.
module tb_hpu_sprite_fetch;
   import hpu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] true_line;
   logic [9:0] true_column;
   logic       busy, done, late;

   always #5 clk = ~clk;

   hpu_sprite_fetch_if fif();

   hpu_sprite_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .true_line   (true_line),
      .true_column (true_column),
      .fif         (fif),
      .busy        (busy),
      .done        (done),
      .late        (late)
   );

   logic [7:0] mem [0:65535];
   always @(posedge clk) fif.data_in <= mem[fif.addr_out];

   typedef struct packed {
      logic [3:0]  idx;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [1:0]  pal;
      logic [23:0] lb;
   } slot_t;

   typedef struct {
      logic [9:0] line;
      logic [7:0] fill_y;
      int         ent;
      logic [7:0] y, x, tile, attr;
      bit         trig;
      bit         hit;
      logic [2:0] row;
      logic [7:0] b0, b1, b2;
   } vec_t;

   slot_t sb_q[$];
   vec_t  vecs[8];

   int tests = 0;
   int fails = 0;
   int jb_busy, jb_done, jb_late, jb_commits;
   logic [9:0] jb_late_col;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      slot_t got, exp;
      @(posedge clk);
      #1;
      if (fif.slot_we === 1'b1) begin
         jb_commits++;
         got = {fif.slot_idx, fif.slot_x, fif.slot_y, fif.slot_pallet, fif.slot_line_buf};
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL slot_unexpected: got write %0h, expected none", got);
         end else begin
            exp = sb_q.pop_front();
            chk("slot_write", 64'(got), 64'(exp));
         end
      end
      if (busy === 1'b1) jb_busy++;
      if (done === 1'b1) jb_done++;
      if (late === 1'b1) begin
         jb_late++;
         jb_late_col = true_column;
      end
   endtask

   task automatic clear_counts();
      jb_busy = 0; jb_done = 0; jb_late = 0; jb_commits = 0; jb_late_col = '0;
   endtask

   // Entry i gets x=i, tile=i, attr=i and a common y.
   task automatic fill_oam(input logic [7:0] y);
      for (int i = 0; i < 40; i++) begin
         mem[32'hFE00 + 4*i + 0] = y;
         mem[32'hFE00 + 4*i + 1] = 8'(i);
         mem[32'hFE00 + 4*i + 2] = 8'(i);
         mem[32'hFE00 + 4*i + 3] = 8'(i);
      end
   endtask

   // Row 0 of tiles 0..39: bytes {i, i+0x40, i+0x80}.
   task automatic set_pat_all();
      for (int i = 0; i < 40; i++) begin
         mem[32'h8000 + 24*i + 0] = 8'(i);
         mem[32'h8000 + 24*i + 1] = 8'(i) + 8'h40;
         mem[32'h8000 + 24*i + 2] = 8'(i) + 8'h80;
      end
   endtask

   function automatic slot_t exp_all(input int slot, input int e);
      slot_t s;
      s.idx = 4'(slot);
      s.x   = 8'(e);
      s.y   = 8'd5;
      s.pal = 2'(e);
      s.lb  = {8'(e) + 8'h80, 8'(e) + 8'h40, 8'(e)};
      return s;
   endfunction

   task automatic run_job(input logic [9:0] line, input bit freeze, input bit stall_en, input int max_cyc);
      int  extra = -1;
      int  stall_left = 0;
      bit  stalled = 1'b0;
      clear_counts();
      true_line   = line;
      true_column = 10'd640;
      for (int c = 0; c < max_cyc; c++) begin
         tick();
         if (stall_en && !stalled && busy && fif.addr_out == 16'hFE01) begin
            stalled     = 1'b1;
            stall_left  = 5;
            fif.bus_gnt = 1'b0;
         end else if (stall_left > 0) begin
            chk("stall_addr_hold", 64'(fif.addr_out), 64'h0FE01);
            stall_left--;
            if (stall_left == 0) fif.bus_gnt = 1'b1;
         end
         if ((jb_done > 0 || jb_late > 0) && extra < 0) extra = 3;
         if (extra == 0) break;
         if (extra > 0) extra--;
         if (freeze) true_column = 10'd641;
         else        true_column = (true_column == 10'd799) ? 10'd0 : true_column + 10'd1;
      end
      if (stall_en) chk("stall_seen", 64'(stalled), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, b0, pa;
      slot_t s;

      // line, fill_y, ent, y, x, tile, attr, trig, hit, row, b0, b1, b2
      vecs[0] = '{10'd9,   8'd200, -1, 8'd0,   8'd0,   8'd0,   8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{10'd9,   8'd200,  3, 8'd3,   8'd17,  8'd2,   8'h02, 1'b1, 1'b1, 3'd2, 8'h11, 8'h22, 8'h33};
      vecs[2] = '{10'd3,   8'd200,  0, 8'd252, 8'd200, 8'd5,   8'h01, 1'b1, 1'b1, 3'd6, 8'hA1, 8'hB2, 8'hC3};
      vecs[3] = '{10'd3,   8'd200,  7, 8'd250, 8'd9,   8'd4,   8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{10'd524, 8'd200, 39, 8'd0,   8'd8,   8'd255, 8'h03, 1'b1, 1'b1, 3'd0, 8'h01, 8'h02, 8'h03};
      vecs[5] = '{10'd523, 8'd200, 20, 8'd255, 8'd99,  8'd17,  8'hFC, 1'b1, 1'b1, 3'd7, 8'h44, 8'h55, 8'h66};
      vecs[6] = '{10'd9,   8'd200, 20, 8'd6,   8'd1,   8'd1,   8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00};
      vecs[7] = '{10'd8,   8'd5,   -1, 8'd0,   8'd0,   8'd0,   8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00};

      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8);
      reset       = 1'b1;
      true_line   = '0;
      true_column = '0;
      fif.bus_gnt = 1'b1;
      clear_counts();
      tick();
      tick();
      chk("reset_outputs",
          64'({fif.bus_req, fif.addr_out, fif.slot_we, fif.slot_idx, fif.slot_enable, busy, done, late}),
          64'd0);
      chk("reset_fields", 64'({fif.slot_x, fif.slot_y, fif.slot_pallet, fif.slot_line_buf}), 64'd0);
      reset = 1'b0;
      tick();

      // Table-driven single-entry scenarios.
      for (int v = 0; v < 8; v++) begin
         fill_oam(vecs[v].fill_y);
         if (vecs[v].ent >= 0) begin
            mem[32'hFE00 + 4*vecs[v].ent + 0] = vecs[v].y;
            mem[32'hFE00 + 4*vecs[v].ent + 1] = vecs[v].x;
            mem[32'hFE00 + 4*vecs[v].ent + 2] = vecs[v].tile;
            mem[32'hFE00 + 4*vecs[v].ent + 3] = vecs[v].attr;
         end
         if (vecs[v].hit) begin
            pa = 32'h8000 + 24*int'(vecs[v].tile) + 3*int'(vecs[v].row);
            mem[(pa + 0) & 32'hFFFF] = vecs[v].b0;
            mem[(pa + 1) & 32'hFFFF] = vecs[v].b1;
            mem[(pa + 2) & 32'hFFFF] = vecs[v].b2;
            s = {4'd0, vecs[v].x, vecs[v].y, vecs[v].attr[1:0], {vecs[v].b2, vecs[v].b1, vecs[v].b0}};
            sb_q.push_back(s);
         end
         run_job(vecs[v].line, 1'b0, 1'b0, vecs[v].trig ? 400 : 30);
         chk($sformatf("v%0d_done", v), 64'(jb_done), 64'(vecs[v].trig));
         chk($sformatf("v%0d_late", v), 64'(jb_late), 64'd0);
         chk($sformatf("v%0d_commits", v), 64'(jb_commits), 64'(vecs[v].hit));
         chk($sformatf("v%0d_sb_empty", v), 64'(sb_q.size()), 64'd0);
         if (vecs[v].trig) begin
            chk($sformatf("v%0d_enable", v), 64'(fif.slot_enable), vecs[v].hit ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_idle", v), 64'({busy, fif.bus_req}), 64'd0);
         end else begin
            chk($sformatf("v%0d_busy", v), 64'(jb_busy), 64'd0);
         end
         if (vecs[v].trig && !vecs[v].hit) chk($sformatf("v%0d_busy_cycles", v), 64'(jb_busy), 64'd120);
         sb_q.delete();
      end

      // All entries hit, column frozen: exactly 16 slots then done.
      fill_oam(8'd5);
      set_pat_all();
      for (int i = 0; i < 16; i++) sb_q.push_back(exp_all(i, i));
      run_job(10'd9, 1'b1, 1'b0, 2000);
      chk("ovf_done", 64'(jb_done), 64'd1);
      chk("ovf_late", 64'(jb_late), 64'd0);
      chk("ovf_commits", 64'(jb_commits), 64'd16);
      chk("ovf_enable", 64'(fif.slot_enable), 64'hFFFF);
      sb_q.delete();

      // All entries hit, column running: abort at 799 keeps committed slots.
      for (int i = 0; i < 16; i++) sb_q.push_back(exp_all(i, i));
      run_job(10'd9, 1'b0, 1'b0, 2000);
      n = jb_commits;
      chk("abort_late", 64'(jb_late), 64'd1);
      chk("abort_done", 64'(jb_done), 64'd0);
      chk("abort_col", 64'(jb_late_col), 64'd799);
      chk("abort_partial", 64'(n > 0 && n < 16), 64'd1);
      chk("abort_enable", 64'(fif.slot_enable), 64'(16'((32'd1 << n) - 1)));
      chk("abort_idle", 64'({busy, fif.bus_req}), 64'd0);
      sb_q.delete();

      // Grant stall in RD_X of entry 0: five extra cycles, same data.
      fill_oam(8'd200);
      mem[32'hFE00] = 8'd5;
      mem[32'hFE01] = 8'd33;
      mem[32'hFE02] = 8'd9;
      mem[32'hFE03] = 8'h01;
      mem[32'h8000 + 24*9 + 0] = 8'h5A;
      mem[32'h8000 + 24*9 + 1] = 8'h6B;
      mem[32'h8000 + 24*9 + 2] = 8'h7C;
      s = {4'd0, 8'd33, 8'd5, 2'd1, 24'h7C6B5A};
      sb_q.push_back(s);
      run_job(10'd9, 1'b0, 1'b0, 400);
      b0 = jb_busy;
      chk("nostall_done", 64'(jb_done), 64'd1);
      sb_q.push_back(s);
      run_job(10'd9, 1'b0, 1'b1, 400);
      chk("stall_done", 64'(jb_done), 64'd1);
      chk("stall_extra", 64'(jb_busy), 64'(b0 + 5));
      chk("stall_sb_empty", 64'(sb_q.size()), 64'd0);
      fif.bus_gnt = 1'b1;
      sb_q.delete();

      // Reset in RD_P1 of entry 1, after entry 0 committed.
      fill_oam(8'd200);
      set_pat_all();
      mem[32'hFE00] = 8'd5;
      mem[32'hFE04] = 8'd5;
      sb_q.push_back(exp_all(0, 0));
      clear_counts();
      true_line   = 10'd9;
      true_column = 10'd640;
      begin
         bit found = 1'b0;
         for (int c = 0; c < 200; c++) begin
            tick();
            if (busy && fif.addr_out == 16'h8019) begin
               found = 1'b1;
               break;
            end
            true_column = true_column + 10'd1;
         end
         chk("rst_reach_p1", 64'(found), 64'd1);
      end
      chk("rst_pre_enable", 64'(fif.slot_enable), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_outputs", 64'({fif.bus_req, busy, fif.slot_we}), 64'd0);
      chk("rst_enable", 64'(fif.slot_enable), 64'd0);
      for (int c = 0; c < 20; c++) begin
         true_column = true_column + 10'd1;
         tick();
      end
      chk("rst_no_pulse", 64'({jb_done[7:0], jb_late[7:0]}), 64'd0);
      chk("rst_commits", 64'(jb_commits), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
